regbank_arbiter: RTL and testbench

Sequencer and two-port arbiter for a bank of NREG sixteen-bit registers built from one-bit binary cells (each register with its own cs and shared w, r, d_in and tri-state d_out). It accepts read/write requests from two requesters, grants the bank to one at a time with round-robin fairness, and drives cs/w/r/d_in for exactly one access cycle per transaction. It captures read data from the shared tri-state d_out bus and reports completion to the winning requester.

---
 rtl/regbank_arbiter_if.sv | 44 ++++
 rtl/regbank_arbiter.sv | 147 ++++++++++++++
 tb/tb_regbank_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_arbiter_if.sv
// regbank_arbiter_if
//   Bundles the two requester channels and the register-bank bus that the
//   arbiter sits between.
//   Requester side : req0/1, we0/1, addr0/1, wdata0/1 (to arbiter)
//                    gnt0/1, done0/1, rdata0/1       (from arbiter)
//   Bank side      : cs, w, r, d_in (from arbiter), d_out (from bank)
//   Modports:
//     slave  - the arbiter's view
//     master - the environment's view (requesters plus the register bank)
interface regbank_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4,
    parameter int AW    = 2
) ();
    logic             req0;
    logic             req1;
    logic             we0;
    logic             we1;
    logic [AW-1:0]    addr0;
    logic [AW-1:0]    addr1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic [NREG-1:0]  cs;
    logic             w;
    logic             r;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, d_out,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, cs, w, r, d_in
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, d_out,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, cs, w, r, d_in
    );
endinterface

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
//   Round-robin arbiter and access sequencer for a bank of NREG registers of
//   WIDTH bits. Each transaction takes IDLE -> ACCESS -> DONE, one cycle each.
//   Ports:
//     clk  - clock, rising edge active
//     rst  - synchronous active-high reset
//     bus  - regbank_arbiter_if.slave: requester channels and bank bus
//   All outputs are registered. The bank itself has no reset; a write strobed
//   in the ACCESS cycle that coincides with rst still lands in the bank.
module regbank_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4,
    parameter int AW    = 2
) (
    input logic               clk,
    input logic               rst,
    regbank_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Requester favoured when both are pending (the one not served last).
    logic prio;
    logic winner;
    logic lat_we;

    logic             any_req;
    logic             pick;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_wdata;

    logic [NREG-1:0]  cs_nxt;
    logic             w_nxt;
    logic             r_nxt;
    logic [WIDTH-1:0] d_in_nxt;
    logic [1:0]       gnt_nxt;
    logic [1:0]       done_nxt;

    function automatic logic [NREG-1:0] addr_to_cs(input logic [AW-1:0] a);
        return NREG'(1) << a;
    endfunction

    // Arbitration: a lone request wins outright; a tie goes to prio.
    always_comb begin
        any_req   = bus.req0 | bus.req1;
        pick      = (bus.req0 && bus.req1) ? prio : bus.req1;
        sel_we    = pick ? bus.we1    : bus.we0;
        sel_addr  = pick ? bus.addr1  : bus.addr0;
        sel_wdata = pick ? bus.wdata1 : bus.wdata0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: computes the values the output registers take for the
    // next cycle, so the strobes appear exactly during ACCESS/DONE.
    always_comb begin
        cs_nxt   = '0;
        w_nxt    = 1'b0;
        r_nxt    = 1'b0;
        d_in_nxt = '0;
        gnt_nxt  = 2'b00;
        done_nxt = 2'b00;
        case (state)
            IDLE: begin
                if (any_req) begin
                    cs_nxt        = addr_to_cs(sel_addr);
                    gnt_nxt[pick] = 1'b1;
                    if (sel_we) begin
                        w_nxt    = 1'b1;
                        d_in_nxt = sel_wdata;
                    end else begin
                        r_nxt    = 1'b1;
                    end
                end
            end
            ACCESS:  done_nxt[winner] = 1'b1;
            default: ;
        endcase
    end

    // Output, transaction and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prio       <= 1'b0;
            winner     <= 1'b0;
            lat_we     <= 1'b0;
            bus.cs     <= '0;
            bus.w      <= 1'b0;
            bus.r      <= 1'b0;
            bus.d_in   <= '0;
            bus.gnt0   <= 1'b0;
            bus.gnt1   <= 1'b0;
            bus.done0  <= 1'b0;
            bus.done1  <= 1'b0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
        end else begin
            bus.cs    <= cs_nxt;
            bus.w     <= w_nxt;
            bus.r     <= r_nxt;
            bus.d_in  <= d_in_nxt;
            bus.gnt0  <= gnt_nxt[0];
            bus.gnt1  <= gnt_nxt[1];
            bus.done0 <= done_nxt[0];
            bus.done1 <= done_nxt[1];

            if (state == IDLE && any_req) begin
                winner <= pick;
                lat_we <= sel_we;
            end

            // Read data is on d_out while r is strobed during ACCESS.
            if (state == ACCESS && !lat_we) begin
                if (winner) bus.rdata1 <= bus.d_out;
                else        bus.rdata0 <= bus.d_out;
            end

            if (state == DONE) prio <= ~winner;
        end
    end

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter
//   Directed bench for regbank_arbiter with a behavioural register bank.
//   Stimulus pushes expected grant and done events (with their cycle numbers)
//   into queues; a monitor on the falling edge pops and compares them.
module tb_regbank_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regbank_arbiter_if #(.WIDTH(16), .NREG(4), .AW(2)) bif ();

    regbank_arbiter #(.WIDTH(16), .NREG(4), .AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Register bank model: no reset, write on rising edge, read onto d_out.
    logic [15:0] bank [0:3];

    always @(posedge clk) begin
        if (bif.w) begin
            for (int i = 0; i < 4; i++)
                if (bif.cs[i]) bank[i] <= bif.d_in;
        end
    end

    always_comb begin
        bif.d_out = '0;
        if (bif.r) begin
            for (int i = 0; i < 4; i++)
                if (bif.cs[i]) bif.d_out = bank[i];
        end
    end

    typedef struct {
        int          cyc;
        bit          id;
        logic [3:0]  cs;
        bit          w;
        bit          r;
        logic [15:0] din;
    } gnt_exp_t;

    typedef struct {
        int          cyc;
        bit          id;
        logic [15:0] rd0;
        logic [15:0] rd1;
    } done_exp_t;

    gnt_exp_t  gq[$];
    done_exp_t dq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_gnt(input int c, input bit id, input logic [3:0] cs,
                            input bit w, input bit r, input logic [15:0] din);
        gnt_exp_t g;
        g.cyc = c; g.id = id; g.cs = cs; g.w = w; g.r = r; g.din = din;
        gq.push_back(g);
    endtask

    task automatic push_done(input int c, input bit id,
                             input logic [15:0] rd0, input logic [15:0] rd1);
        done_exp_t d;
        d.cyc = c; d.id = id; d.rd0 = rd0; d.rd1 = rd1;
        dq.push_back(d);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cs",     32'(bif.cs),     0);
        chk("rst_w",      32'(bif.w),      0);
        chk("rst_r",      32'(bif.r),      0);
        chk("rst_d_in",   32'(bif.d_in),   0);
        chk("rst_gnt0",   32'(bif.gnt0),   0);
        chk("rst_gnt1",   32'(bif.gnt1),   0);
        chk("rst_done0",  32'(bif.done0),  0);
        chk("rst_done1",  32'(bif.done1),  0);
        chk("rst_rdata0", 32'(bif.rdata0), 0);
        chk("rst_rdata1", 32'(bif.rdata1), 0);
    endtask

    // Monitor: invariants every cycle, scoreboard on grant and done.
    always @(negedge clk) begin
        chk("no_w_and_r",   32'(bif.w && bif.r), 0);
        chk("cs_onehot0",   32'($onehot0(bif.cs)), 1);
        chk("cs_iff_gnt",   32'(bif.cs != 4'b0), 32'(bif.gnt0 | bif.gnt1));
        chk("gnt_exclusive", 32'(bif.gnt0 & bif.gnt1), 0);
        chk("done_exclusive", 32'(bif.done0 & bif.done1), 0);

        if (bif.gnt0 || bif.gnt1) begin
            if (gq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_gnt: gnt0=%b gnt1=%b at cycle %0d, required none",
                         bif.gnt0, bif.gnt1, cyc);
            end else begin
                gnt_exp_t g;
                g = gq.pop_front();
                chk("gnt_cycle", cyc, g.cyc);
                chk("gnt_id",    32'(bif.gnt1), 32'(g.id));
                chk("gnt_cs",    32'(bif.cs),   32'(g.cs));
                chk("gnt_w",     32'(bif.w),    32'(g.w));
                chk("gnt_r",     32'(bif.r),    32'(g.r));
                chk("gnt_d_in",  32'(bif.d_in), 32'(g.din));
            end
        end

        if (bif.done0 || bif.done1) begin
            if (dq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: done0=%b done1=%b at cycle %0d, required none",
                         bif.done0, bif.done1, cyc);
            end else begin
                done_exp_t d;
                d = dq.pop_front();
                chk("done_cycle",  cyc, d.cyc);
                chk("done_id",     32'(bif.done1),  32'(d.id));
                chk("done_rdata0", 32'(bif.rdata0), 32'(d.rd0));
                chk("done_rdata1", 32'(bif.rdata1), 32'(d.rd1));
            end
        end
    end

    initial begin
        int c;
        rst = 1'b1;
        bif.req0 = 0; bif.req1 = 0; bif.we0 = 0; bif.we1 = 0;
        bif.addr0 = '0; bif.addr1 = '0; bif.wdata0 = '0; bif.wdata1 = '0;
        for (int i = 0; i < 4; i++) bank[i] = '0;
        step(2);
        chk_reset_outputs();
        rst = 1'b0;

        // Single write: req0 addr 2 <= A5C3
        c = cyc;
        bif.req0 = 1; bif.we0 = 1; bif.addr0 = 2'd2; bif.wdata0 = 16'hA5C3;
        push_gnt(c + 1, 0, 4'b0100, 1, 0, 16'hA5C3);
        push_done(c + 2, 0, 16'h0000, 16'h0000);
        step(2);
        bif.req0 = 0;
        step(1);

        // Read back addr 2 on requester 0
        c = cyc;
        bif.req0 = 1; bif.we0 = 0; bif.addr0 = 2'd2;
        push_gnt(c + 1, 0, 4'b0100, 0, 1, 16'h0000);
        push_done(c + 2, 0, 16'hA5C3, 16'h0000);
        step(2);
        bif.req0 = 0;
        step(1);

        // Reset, then simultaneous: req0 writes addr 1, req1 reads it
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        c = cyc;
        bif.req0 = 1; bif.we0 = 1; bif.addr0 = 2'd1; bif.wdata0 = 16'h1111;
        bif.req1 = 1; bif.we1 = 0; bif.addr1 = 2'd1;
        push_gnt(c + 1, 0, 4'b0010, 1, 0, 16'h1111);
        push_done(c + 2, 0, 16'h0000, 16'h0000);
        push_gnt(c + 4, 1, 4'b0010, 0, 1, 16'h0000);
        push_done(c + 5, 1, 16'h0000, 16'h1111);
        step(2);
        bif.req0 = 0;
        step(3);
        bif.req1 = 0;
        step(1);

        // Both held for 12 cycles, all reads: grants alternate 0,1,0,1
        c = cyc;
        bif.req0 = 1; bif.we0 = 0; bif.addr0 = 2'd1;
        bif.req1 = 1; bif.we1 = 0; bif.addr1 = 2'd2;
        for (int k = 0; k < 4; k++) begin
            bit id;
            id = bit'(k % 2);
            push_gnt(c + 1 + 3 * k, id, id ? 4'b0100 : 4'b0010, 0, 1, 16'h0000);
            push_done(c + 2 + 3 * k, id, 16'h1111, (k >= 1) ? 16'hA5C3 : 16'h1111);
        end
        step(11);
        bif.req0 = 0; bif.req1 = 0;
        step(1);

        // Reset during req1's read ACCESS: no done, outputs back to reset
        c = cyc;
        bif.req1 = 1; bif.we1 = 0; bif.addr1 = 2'd1;
        push_gnt(c + 1, 1, 4'b0010, 0, 1, 16'h0000);
        step(1);
        rst = 1'b1;
        bif.req1 = 0;
        step(1);
        chk_reset_outputs();
        rst = 1'b0;

        // Simultaneous request after reset goes to requester 0 first
        c = cyc;
        bif.req0 = 1; bif.we0 = 0; bif.addr0 = 2'd2;
        bif.req1 = 1; bif.we1 = 0; bif.addr1 = 2'd1;
        push_gnt(c + 1, 0, 4'b0100, 0, 1, 16'h0000);
        push_done(c + 2, 0, 16'hA5C3, 16'h0000);
        push_gnt(c + 4, 1, 4'b0010, 0, 1, 16'h0000);
        push_done(c + 5, 1, 16'hA5C3, 16'h1111);
        step(2);
        bif.req0 = 0;
        step(3);
        bif.req1 = 0;
        step(3);

        chk("gnt_queue_drained",  32'(gq.size()), 0);
        chk("done_queue_drained", 32'(dq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
